decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width of pc_in, pc_out and imm_out; legal values are 32 and 64.
REQ-002 Parameter LOAD_USE_BUBBLES, default 1, SHALL set the number of bubble cycles inserted on a load-use hazard; legal range is 1..3.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 flush  in  1  SHALL be a synchronous pipeline flush request.
REQ-006 in_valid  in  1  SHALL mean the fetch stage offers an instruction.
REQ-007 in_ready  out  1  SHALL mean the stage accepts the instruction this cycle.
REQ-008 inst_in  in  32  SHALL carry the raw RV instruction.
REQ-009 pc_in  in  XLEN  SHALL carry the instruction PC.
REQ-010 out_valid  out  1  SHALL mean the output register holds a decoded instruction.
REQ-011 out_ready  in  1  SHALL mean the execute stage consumes the output this cycle.
REQ-012 rs1_out, rs2_out, rd_out  out  5 each  SHALL carry register-file addresses.
REQ-013 imm_out  out  XLEN  SHALL carry the sign-extended immediate.
REQ-014 alu_op  out  4  SHALL carry the ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10.
REQ-015 reg_we, mem_re, mem_we, src_b_imm, illegal  out  1 each  SHALL be control flags.
REQ-016 mem_size  out  3  SHALL carry funct3 for loads and stores, and 0 otherwise.
REQ-017 pc_out  out  XLEN  SHALL carry the PC of the held instruction.

Function
REQ-018 Decode SHALL support these opcodes: I-imm 0010011, LOAD 0000011, R-type 0110011, STORE 0100011, LUI 0110111.
REQ-019 I-imm SHALL decode as follows.
- funct3 000/111/110/100/010/011 SHALL map to ADD/AND/OR/XOR/SLT/SLTU.
- funct3 001 SHALL map to SLL.
- funct3 101 SHALL map to SRL, or to SRA when inst[30]=1.
- Outputs SHALL be reg_we=1 and src_b_imm=1.
REQ-020 R-type SHALL use the same funct3 map, except that funct3 000 with inst[30]=1 SHALL map to SUB; outputs SHALL be reg_we=1 and src_b_imm=0.
REQ-021 LOAD SHALL decode as alu_op=ADD, reg_we=1, mem_re=1, src_b_imm=1, mem_size=funct3.
REQ-022 STORE SHALL decode as alu_op=ADD, mem_we=1, reg_we=0, src_b_imm=1, imm={inst[31:25],inst[11:7]} sign-extended; rd_out SHALL be 0.
REQ-023 LUI SHALL decode as alu_op=PASSB, imm={inst[31:12],12'b0} sign-extended to XLEN, reg_we=1, src_b_imm=1, rs1_out=0.
REQ-024 I-type immediates SHALL be inst[31:20] sign-extended to XLEN.
REQ-025 Any other opcode SHALL be passed as a NOP with illegal=1: all enables 0, alu_op=0, imm_out=0, rs/rd=0.
REQ-026 The output register SHALL be loaded only on an accept (in_valid && in_ready), with latency of exactly 1 cycle from accept to out_valid=1.
REQ-027 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-028 When out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-029 When the output is consumed with no new accept, out_valid SHALL drop to 0 on the next cycle.
REQ-030 Hazard tracking SHALL use a last_load_rd register.
- It SHALL be set to rd on accepting a LOAD with rd!=0.
- It SHALL be cleared to 0 on accepting any other instruction, and on flush.
REQ-031 hazard SHALL be 1 when in_valid=1, last_load_rd!=0, inst_in uses rs1 or rs2 (R-type and STORE use both; I-imm and LOAD use rs1; LUI uses neither) equal to last_load_rd, and bubble_cnt < LOAD_USE_BUBBLES.
REQ-032 bubble_cnt SHALL be a 2-bit counter.
- It SHALL increment on each cycle where hazard=1 and the slot is free (!out_valid || out_ready).
- It SHALL reset to 0 on accept or flush.
- Once bubble_cnt reaches LOAD_USE_BUBBLES, hazard SHALL drop and the dependent instruction SHALL be accepted with last_load_rd cleared.
REQ-033 While hazard=1, out_valid SHALL become 0 once the held instruction is consumed; bubbles SHALL be emitted as out_valid=0.
REQ-034 Flush SHALL clear out_valid, bubble_cnt and last_load_rd on the next edge.
- in_ready SHALL be 0 during flush.
- Flush SHALL override a simultaneous accept.
- An instruction presented during flush SHALL be dropped, not accepted.
REQ-035 x0 SHALL never create a hazard.

Reset
REQ-036 On rst_n=0, all outputs and state SHALL go to 0 immediately and asynchronously: out_valid, flags, alu_op, imm_out, pc_out, rs/rd, last_load_rd, bubble_cnt.
REQ-037 While rst_n=0, in_ready SHALL be 0.
REQ-038 Reset asserted mid-stall SHALL abandon the hazard, and the first cycle after release SHALL accept normally.

Verification
REQ-039 ori x1,x2,-1: inst 0xFFF16093 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, alu_op=3, reg_we=1, src_b_imm=1.
REQ-040 lw x5,8(x3) 0x0081A283 then add x6,x5,x5 0x00528333, out_ready=1 -> lw out (mem_re=1, imm=8, mem_size=2), one cycle out_valid=0, then add (rs1=rs2=5, rd=6, alu_op=0).
REQ-041 sw x7,-4(x2): inst 0xFE712E23 -> mem_we=1, reg_we=0, rs1=2, rs2=7, imm=0xFFFFFFFC, rd=0.
REQ-042 out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0 and outputs unchanged; the next instruction is accepted on the cycle after out_ready=1.
REQ-043 Flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the instruction is not latched.
- Variant: flush issued after a load, and the load-dependent add is presented after flush -> add accepted without a bubble.
REQ-044 inst 0x0000007F -> out_valid=1, illegal=1, all enables 0.
- Variant: rst_n pulsed low mid-stall -> outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// RV32/RV64 subset decode stage: one output register with valid/ready handshake,
// plus load-use hazard detection that inserts a configurable number of bubbles.
module decode_stage #(
    parameter int XLEN             = 32,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] imm_out,
    output logic [3:0]      alu_op,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            src_b_imm,
    output logic            illegal,
    output logic [2:0]      mem_size,
    output logic [XLEN-1:0] pc_out
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] BUBBLES = 2'(LOAD_USE_BUBBLES);

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic       alt,
                                                   input logic       allow_sub);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      f_rs1, f_rs2, f_rd;
    logic [XLEN-1:0] i_imm, s_imm, u_imm;

    assign opcode = inst_in[6:0];
    assign funct3 = inst_in[14:12];
    assign f_rd   = inst_in[11:7];
    assign f_rs1  = inst_in[19:15];
    assign f_rs2  = inst_in[24:20];
    assign i_imm  = XLEN'($signed(inst_in[31:20]));
    assign s_imm  = XLEN'($signed({inst_in[31:25], inst_in[11:7]}));
    assign u_imm  = XLEN'($signed({inst_in[31:12], 12'b0}));

    logic [4:0]      rs1_next, rs2_next, rd_next;
    logic [XLEN-1:0] imm_next;
    logic [3:0]      alu_op_next;
    logic            reg_we_next, mem_re_next, mem_we_next, src_b_imm_next, illegal_next;
    logic [2:0]      mem_size_next;
    logic            uses_rs1, uses_rs2, is_load;

    // Fields an instruction does not use are forced to zero so downstream never sees stale indices.
    always_comb begin
        rs1_next       = '0;
        rs2_next       = '0;
        rd_next        = '0;
        imm_next       = '0;
        alu_op_next    = ALU_ADD;
        reg_we_next    = 1'b0;
        mem_re_next    = 1'b0;
        mem_we_next    = 1'b0;
        src_b_imm_next = 1'b0;
        illegal_next   = 1'b0;
        mem_size_next  = '0;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        is_load        = 1'b0;
        case (opcode)
            OP_IMM: begin
                alu_op_next    = alu_from_funct3(funct3, inst_in[30], 1'b0);
                reg_we_next    = 1'b1;
                src_b_imm_next = 1'b1;
                rs1_next       = f_rs1;
                rd_next        = f_rd;
                imm_next       = i_imm;
                uses_rs1       = 1'b1;
            end
            OP_LOAD: begin
                reg_we_next    = 1'b1;
                mem_re_next    = 1'b1;
                src_b_imm_next = 1'b1;
                mem_size_next  = funct3;
                rs1_next       = f_rs1;
                rd_next        = f_rd;
                imm_next       = i_imm;
                uses_rs1       = 1'b1;
                is_load        = 1'b1;
            end
            OP_REG: begin
                alu_op_next = alu_from_funct3(funct3, inst_in[30], 1'b1);
                reg_we_next = 1'b1;
                rs1_next    = f_rs1;
                rs2_next    = f_rs2;
                rd_next     = f_rd;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_STORE: begin
                mem_we_next    = 1'b1;
                src_b_imm_next = 1'b1;
                mem_size_next  = funct3;
                rs1_next       = f_rs1;
                rs2_next       = f_rs2;
                imm_next       = s_imm;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_LUI: begin
                alu_op_next    = ALU_PASSB;
                reg_we_next    = 1'b1;
                src_b_imm_next = 1'b1;
                rd_next        = f_rd;
                imm_next       = u_imm;
            end
            default: illegal_next = 1'b1;
        endcase
    end

    logic            out_valid_reg;
    logic [4:0]      rs1_reg, rs2_reg, rd_reg;
    logic [XLEN-1:0] imm_reg, pc_reg;
    logic [3:0]      alu_op_reg;
    logic            reg_we_reg, mem_re_reg, mem_we_reg, src_b_imm_reg, illegal_reg;
    logic [2:0]      mem_size_reg;
    logic [4:0]      last_load_rd_reg;
    logic [1:0]      bubble_cnt_reg;

    logic hazard, slot_free, accept, rs1_hit, rs2_hit;

    // last_load_rd is never x0, so a zero source index cannot match and x0 never stalls.
    assign rs1_hit   = uses_rs1 && (f_rs1 == last_load_rd_reg);
    assign rs2_hit   = uses_rs2 && (f_rs2 == last_load_rd_reg);
    assign hazard    = in_valid && (last_load_rd_reg != 5'd0) && (rs1_hit || rs2_hit)
                       && (bubble_cnt_reg < BUBBLES);
    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = rst_n && slot_free && !hazard && !flush;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg    <= 1'b0;
            rs1_reg          <= '0;
            rs2_reg          <= '0;
            rd_reg           <= '0;
            imm_reg          <= '0;
            pc_reg           <= '0;
            alu_op_reg       <= '0;
            reg_we_reg       <= 1'b0;
            mem_re_reg       <= 1'b0;
            mem_we_reg       <= 1'b0;
            src_b_imm_reg    <= 1'b0;
            illegal_reg      <= 1'b0;
            mem_size_reg     <= '0;
            last_load_rd_reg <= '0;
            bubble_cnt_reg   <= '0;
        end else if (flush) begin
            out_valid_reg    <= 1'b0;
            last_load_rd_reg <= '0;
            bubble_cnt_reg   <= '0;
        end else if (accept) begin
            out_valid_reg    <= 1'b1;
            rs1_reg          <= rs1_next;
            rs2_reg          <= rs2_next;
            rd_reg           <= rd_next;
            imm_reg          <= imm_next;
            pc_reg           <= pc_in;
            alu_op_reg       <= alu_op_next;
            reg_we_reg       <= reg_we_next;
            mem_re_reg       <= mem_re_next;
            mem_we_reg       <= mem_we_next;
            src_b_imm_reg    <= src_b_imm_next;
            illegal_reg      <= illegal_next;
            mem_size_reg     <= mem_size_next;
            last_load_rd_reg <= (is_load && f_rd != 5'd0) ? f_rd : 5'd0;
            bubble_cnt_reg   <= '0;
        end else begin
            if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // Bubbles only count when the slot could otherwise have taken the instruction.
            if (hazard && slot_free) begin
                bubble_cnt_reg <= bubble_cnt_reg + 2'd1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign rs1_out   = rs1_reg;
    assign rs2_out   = rs2_reg;
    assign rd_out    = rd_reg;
    assign imm_out   = imm_reg;
    assign pc_out    = pc_reg;
    assign alu_op    = alu_op_reg;
    assign reg_we    = reg_we_reg;
    assign mem_re    = mem_re_reg;
    assign mem_we    = mem_we_reg;
    assign src_b_imm = src_b_imm_reg;
    assign illegal   = illegal_reg;
    assign mem_size  = mem_size_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scenario tasks with inline checks plus a scoreboard
// that compares every consumed output against the expectation queued at accept time.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     inst_in;
    logic [XLEN-1:0] pc_in, imm_out, pc_out;
    logic [4:0]      rs1_out, rs2_out, rd_out;
    logic [3:0]      alu_op;
    logic            reg_we, mem_re, mem_we, src_b_imm, illegal;
    logic [2:0]      mem_size;

    decode_stage #(.XLEN(XLEN), .LOAD_USE_BUBBLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .imm_out(imm_out),
        .alu_op(alu_op), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .src_b_imm(src_b_imm), .illegal(illegal), .mem_size(mem_size), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  fl;   // {reg_we, mem_re, mem_we, src_b_imm, illegal}
        logic [2:0]  ms;
        logic [31:0] pc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;

    function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [3:0] alu, input logic [4:0] fl,
                                input logic [2:0] ms, input logic [31:0] pc);
        exp_t e;
        e = '{rs1: rs1, rs2: rs2, rd: rd, imm: imm, alu: alu, fl: fl, ms: ms, pc: pc};
        return e;
    endfunction

    // Scoreboard: pop on consume, then push on accept (same sample point, one process).
    always @(negedge clk) begin
        exp_t obs, e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                obs = '{rs1: rs1_out, rs2: rs2_out, rd: rd_out, imm: imm_out, alu: alu_op,
                        fl: {reg_we, mem_re, mem_we, src_b_imm, illegal}, ms: mem_size, pc: pc_out};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output got=%h required=none", obs);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL sb_contents pc=%h got=%h required=%h", e.pc, obs, e);
                    end else begin
                        $display("txn out pc=%h rd=%0d alu=%0d imm=%h ok", pc_out, rd_out, alu_op, imm_out);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input exp_t e);
        in_valid = 1'b1;
        inst_in  = inst;
        pc_in    = e.pc;
        cur_exp  = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        inst_in  = 32'h0000_0013;
    endtask

    // Hand-derived expectations for the instruction set exercised below.
    function automatic exp_t e_ori(input logic [31:0] pc);  return mk(2, 0, 1, 32'hFFFF_FFFF, 3, 5'b10010, 0, pc); endfunction
    function automatic exp_t e_lw(input logic [31:0] pc);   return mk(3, 0, 5, 32'h8, 0, 5'b11010, 2, pc); endfunction
    function automatic exp_t e_add(input logic [31:0] pc);  return mk(5, 5, 6, 32'h0, 0, 5'b10000, 0, pc); endfunction
    function automatic exp_t e_sw(input logic [31:0] pc);   return mk(2, 7, 0, 32'hFFFF_FFFC, 0, 5'b00110, 2, pc); endfunction
    function automatic exp_t e_sub(input logic [31:0] pc);  return mk(4, 5, 3, 32'h0, 1, 5'b10000, 0, pc); endfunction
    function automatic exp_t e_xor(input logic [31:0] pc);  return mk(20, 21, 19, 32'h0, 4, 5'b10000, 0, pc); endfunction
    function automatic exp_t e_ill(input logic [31:0] pc);  return mk(0, 0, 0, 32'h0, 0, 5'b00001, 0, pc); endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        inst_in = 32'hFFF1_6093; pc_in = 32'h0;
        #3;
        checks++;
        if ({in_ready, out_valid, rd_out, rs1_out, imm_out, pc_out, alu_op} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%h/%h required=0", in_ready, out_valid, imm_out, pc_out);
        end
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ori();
        present(32'hFFF1_6093, e_ori(32'h100));
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ori_in_ready got=%b required=1", in_ready); end
        step();
        idle();
        checks++;
        if ({out_valid, rd_out, rs1_out, imm_out, alu_op, reg_we, src_b_imm} !==
            {1'b1, 5'd1, 5'd2, 32'hFFFF_FFFF, 4'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ori_decode got=v%b rd%0d rs1%0d imm%h alu%0d required=v1 rd1 rs1_2 immffffffff alu3",
                     out_valid, rd_out, rs1_out, imm_out, alu_op);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ori_drain got=%b required=0", out_valid); end
    endtask

    task automatic test_load_use();
        present(32'h0081_A283, e_lw(32'h200));
        step();
        present(32'h0052_8333, e_add(32'h204));
        #1;
        checks++;
        if ({in_ready, out_valid, mem_re, imm_out, mem_size} !== {1'b0, 1'b1, 1'b1, 32'h8, 3'd2}) begin
            errors++;
            $display("FAIL lu_load_out got=rdy%b v%b re%b imm%h sz%0d required=rdy0 v1 re1 imm8 sz2",
                     in_ready, out_valid, mem_re, imm_out, mem_size);
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL lu_bubble got=v%b rdy%b required=v0 rdy1", out_valid, in_ready);
        end
        step();
        idle();
        checks++;
        if ({out_valid, rs1_out, rs2_out, rd_out, alu_op} !== {1'b1, 5'd5, 5'd5, 5'd6, 4'd0}) begin
            errors++;
            $display("FAIL lu_add_out got=v%b rs1 %0d rs2 %0d rd %0d alu %0d required=v1 5 5 6 0",
                     out_valid, rs1_out, rs2_out, rd_out, alu_op);
        end
        step();
    endtask

    task automatic test_store();
        present(32'hFE71_2E23, e_sw(32'h300));
        step();
        idle();
        checks++;
        if ({out_valid, mem_we, reg_we, rs1_out, rs2_out, imm_out, rd_out} !==
            {1'b1, 1'b1, 1'b0, 5'd2, 5'd7, 32'hFFFF_FFFC, 5'd0}) begin
            errors++;
            $display("FAIL store_decode got=we%b rwe%b rs1 %0d rs2 %0d imm%h rd%0d required=we1 rwe0 2 7 fffffffc 0",
                     mem_we, reg_we, rs1_out, rs2_out, imm_out, rd_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [10];
        exp_t        exps  [10];
        insts[0] = 32'h4052_01B3; exps[0] = e_sub(32'h1000);
        insts[1] = 32'h40A4_D433; exps[1] = mk(9, 10, 8, 32'h0, 7, 5'b10000, 0, 32'h1004);
        insts[2] = 32'h00D6_35B3; exps[2] = mk(12, 13, 11, 32'h0, 9, 5'b10000, 0, 32'h1008);
        insts[3] = 32'h4037_D713; exps[3] = mk(15, 0, 14, 32'h403, 7, 5'b10010, 0, 32'h100C);
        insts[4] = 32'h0049_1893; exps[4] = mk(18, 0, 17, 32'h4, 5, 5'b10010, 0, 32'h1010);
        insts[5] = 32'h015A_49B3; exps[5] = e_xor(32'h1014);
        insts[6] = 32'hFE71_2E23; exps[6] = e_sw(32'h1018);
        insts[7] = 32'hFFF0_8B03; exps[7] = mk(1, 0, 22, 32'hFFFF_FFFF, 0, 5'b11010, 0, 32'h101C);
        insts[8] = 32'hABCD_E837; exps[8] = mk(0, 0, 16, 32'hABCD_E000, 10, 5'b10010, 0, 32'h1020);
        insts[9] = 32'hFFF1_6093; exps[9] = e_ori(32'h1024);
        for (int i = 0; i < 10; i++) begin
            present(insts[i], exps[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready idx=%0d got=%b required=1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_out_valid idx=%0d got=%b required=1", i, out_valid);
            end
        end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        present(32'h015A_49B3, e_xor(32'h2000));
        step();
        out_ready = 1'b0;
        present(32'h4052_01B3, e_sub(32'h2004));
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, rd_out, alu_op, pc_out} !== {1'b0, 1'b1, 5'd19, 4'd4, 32'h2000}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=rdy%b v%b rd%0d alu%0d pc%h required=rdy0 v1 rd19 alu4 pc2000",
                         i, in_ready, out_valid, rd_out, alu_op, pc_out);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b required=1", in_ready); end
        step();
        idle();
        checks++;
        if ({out_valid, rd_out, pc_out} !== {1'b1, 5'd3, 32'h2004}) begin
            errors++; $display("FAIL bp_next got=v%b rd%0d pc%h required=v1 rd3 pc2004", out_valid, rd_out, pc_out);
        end
        step();
    endtask

    task automatic test_flush();
        present(32'hFFF1_6093, e_ori(32'h400));
        step();
        present(32'h4052_01B3, e_sub(32'h404));
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b required=0", in_ready); end
        step();
        flush = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got=%b required=0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b required=0", out_valid); end
    endtask

    task automatic test_flush_load();
        present(32'h0081_A283, e_lw(32'h500));
        step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        present(32'h0052_8333, e_add(32'h504));
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_load_nobubble got=%b required=1", in_ready); end
        step();
        idle();
        checks++;
        if ({out_valid, rd_out} !== {1'b1, 5'd6}) begin
            errors++; $display("FAIL flush_load_add got=v%b rd%0d required=v1 rd6", out_valid, rd_out);
        end
        step();
    endtask

    task automatic test_illegal();
        present(32'h0000_007F, e_ill(32'h700));
        step();
        idle();
        checks++;
        if ({out_valid, illegal, reg_we, mem_re, mem_we, src_b_imm, alu_op, imm_out, rs1_out, rs2_out, rd_out} !==
            {1'b1, 1'b1, 4'b0000, 4'd0, 32'h0, 15'd0}) begin
            errors++;
            $display("FAIL illegal_nop got=v%b ill%b en%b%b%b%b alu%0d imm%h required=v1 ill1 en0000 alu0 imm0",
                     out_valid, illegal, reg_we, mem_re, mem_we, src_b_imm, alu_op, imm_out);
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        present(32'h0081_A283, e_lw(32'h600));
        step();
        out_ready = 1'b0;
        present(32'h0052_8333, e_add(32'h604));
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_setup got=%b required=0", in_ready); end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, mem_re, rd_out, rs1_out, imm_out, pc_out, mem_size} !== '0) begin
            errors++;
            $display("FAIL rst_async got=v%b rdy%b re%b rd%0d imm%h pc%h required=all0",
                     out_valid, in_ready, mem_re, rd_out, imm_out, pc_out);
        end
        sb.delete();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_accept got=%b required=1", in_ready); end
        step();
        idle();
        checks++;
        if ({out_valid, rd_out, pc_out} !== {1'b1, 5'd6, 32'h604}) begin
            errors++; $display("FAIL rst_release_out got=v%b rd%0d pc%h required=v1 rd6 pc604", out_valid, rd_out, pc_out);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_ori();
        test_load_use();
        test_store();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_flush_load();
        test_illegal();
        test_reset_mid_stall();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drained got=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
